subkey_h_powers_engine: RTL



---
 rtl/subkey_h_powers_engine.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/subkey_h_powers_engine.sv
// GHASH subkey power engine: computes H^1..H^N over GF(2^128) (GCM
// polynomial, reflected bit order) with a digit-serial multiplier that
// consumes NB_STEP bits of the multiplier operand per enabled cycle.
// Each power is written to its own bus slot with a per-slot valid flag.
module subkey_h_powers_engine #(
  parameter int NB_DATA   = 128,
  parameter int MAX_POWER = 8,
  parameter int NB_SEL    = 4,
  parameter int NB_STEP   = 1
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic                           i_valid,
  input  logic                           i_trigger,
  input  logic                           i_abort,
  input  logic [NB_SEL-1:0]              i_num_powers,
  input  logic [NB_DATA-1:0]             i_subkey_h,
  output logic [MAX_POWER*NB_DATA-1:0]   o_h_power_bus,
  output logic [MAX_POWER-1:0]           o_h_power_valid,
  output logic                           o_busy,
  output logic                           o_powers_ready
);

  // Cycles per product and the iteration counter width (at least one bit).
  localparam int P       = NB_DATA / NB_STEP;
  localparam int NB_ITER = (P > 1) ? $clog2(P) : 1;
  localparam logic [NB_ITER-1:0] ITER_LAST = NB_ITER'(P - 1);
  // Reduction constant: x^0 + x^1 + x^2 + x^7 in reflected order.
  localparam logic [NB_DATA-1:0] R_POLY = {8'hE1, {(NB_DATA-8){1'b0}}};

  // Reject configurations the field arithmetic cannot support.
  if (NB_DATA != 128) begin : g_bad_width
    $error("subkey_h_powers_engine: NB_DATA must be 128");
  end
  if ((NB_STEP < 1) || (NB_DATA % NB_STEP != 0)) begin : g_bad_step
    $error("subkey_h_powers_engine: NB_STEP must divide NB_DATA");
  end
  if ((MAX_POWER < 1) || ((1 << NB_SEL) <= MAX_POWER)) begin : g_bad_sel
    $error("subkey_h_powers_engine: need MAX_POWER >= 1 and 2^NB_SEL > MAX_POWER");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [NB_DATA-1:0]   h_q;
  logic [NB_DATA-1:0]   v_q;
  logic [NB_DATA-1:0]   y_q;
  logic [NB_DATA-1:0]   z_q;
  logic [NB_DATA-1:0]   v_d;
  logic [NB_DATA-1:0]   z_d;
  logic [NB_SEL-1:0]    k_q;
  logic [NB_SEL-1:0]    n_q;
  logic [NB_SEL-1:0]    n_clamp;
  logic [NB_ITER-1:0]   iter_q;
  logic [NB_DATA-1:0]   slot_q [MAX_POWER];
  logic [MAX_POWER-1:0] valid_q;
  logic                 busy_q;
  logic                 ready_q;

  // Clamp the requested power count into 1..MAX_POWER.
  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    n_clamp = i_num_powers;
    if (i_num_powers == '0) begin
      n_clamp = NB_SEL'(1);
    end else if (i_num_powers > NB_SEL'(MAX_POWER)) begin
      n_clamp = NB_SEL'(MAX_POWER);
    end
  end

  // One digit of the shift-and-add multiply: consume NB_STEP bits of Y, x^0 first.
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    for (int j = 0; j < NB_STEP; j++) begin
      // NOTE: blocking assignments here chain the NB_STEP sub-steps within one cycle.
      if (y_q[NB_DATA-1-j]) begin
        z_d = z_d ^ v_d;
      end
      v_d = v_d[0] ? ((v_d >> 1) ^ R_POLY) : (v_d >> 1);
    end
  end

  // Control FSM, multiplier datapath registers and the result slots.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      iter_q  <= '0;
      // NOTE: the slots are visible outputs that must read zero after reset, so unlike a plain storage array they are reset.
      for (int s = 0; s < MAX_POWER; s++) begin
        slot_q[s] <= '0;
      end
      valid_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else if (i_valid) begin
      if (i_trigger) begin
        // New key: H^1 is H itself, every other slot is stale.
        h_q <= i_subkey_h;
        n_q <= n_clamp;
        for (int s = 0; s < MAX_POWER; s++) begin
          slot_q[s] <= (s == 0) ? i_subkey_h : '0;
        end
        valid_q <= MAX_POWER'(1);
        v_q     <= i_subkey_h;
        y_q     <= i_subkey_h;
        z_q     <= '0;
        k_q     <= NB_SEL'(1);
        iter_q  <= '0;
        if (n_clamp == NB_SEL'(1)) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end else begin
          state_q <= S_MULT;
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
        end
      end else if (i_abort) begin
        // Completed slots stay; any partial product is simply abandoned.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        ready_q <= 1'b0;
      end else if (state_q == S_MULT) begin
        if (iter_q == ITER_LAST) begin
          for (int s = 0; s < MAX_POWER; s++) begin
            if (k_q == NB_SEL'(s)) begin
              slot_q[s]  <= z_d;
              valid_q[s] <= 1'b1;
            end
          end
          if (k_q == n_q - NB_SEL'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            // Next power = previous power * H, started without a gap cycle.
            y_q    <= z_d;
            v_q    <= h_q;
            z_q    <= '0;
            k_q    <= k_q + NB_SEL'(1);
            iter_q <= '0;
          end
        end else begin
          z_q    <= z_d;
          v_q    <= v_d;
          y_q    <= y_q << NB_STEP;
          iter_q <= iter_q + NB_ITER'(1);
        end
      end
    end
  end

  // Slot k occupies bus bits [(k+1)*NB_DATA-1 -: NB_DATA].
  for (genvar g = 0; g < MAX_POWER; g++) begin : g_bus
    assign o_h_power_bus[(g+1)*NB_DATA-1 -: NB_DATA] = slot_q[g];
  end

  assign o_h_power_valid = valid_q;
  assign o_busy          = busy_q;
  assign o_powers_ready  = ready_q;

endmodule
